id_ex_pipe: RTL

ID/EX pipeline register of the five-stage MIPS core, sitting directly downstream of the instruction decoder/control unit. Each cycle it captures the decoded control word (regwrite, memtoreg, memwrite, alusrc, regdst, jump, branch, branch_condition, alucontrol) and the ID-stage operands, and presents them to the EX stage. It also provides:
- load-use hazard detection, which inserts a one-cycle bubble;
- branch/jump flush;
- a saturating bubble counter for performance measurement.

---
 rtl/id_ex_pipe.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/id_ex_pipe.sv
// ID/EX pipeline register with load-use stall, flush and bubble counter.
// Define ID_EX_HAZARD_DETECT_EN to enable load-use detection and bubble counting.
module id_ex_pipe #(
  parameter int DW   = 32,
  parameter int CNTW = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush_i,
  input  logic            id_valid_i,
  input  logic            id_regwrite_i,
  input  logic            id_memtoreg_i,
  input  logic            id_memwrite_i,
  input  logic            id_alusrc_i,
  input  logic            id_regdst_i,
  input  logic            id_jump_i,
  input  logic            id_branch_i,
  input  logic [1:0]      id_branch_condition_i,
  input  logic [3:0]      id_alucontrol_i,
  input  logic [DW-1:0]   id_rd1_i,
  input  logic [DW-1:0]   id_rd2_i,
  input  logic [DW-1:0]   id_imm_i,
  input  logic [DW-1:0]   id_pcplus4_i,
  input  logic [4:0]      id_rs_i,
  input  logic [4:0]      id_rt_i,
  input  logic [4:0]      id_rd_i,
  input  logic [4:0]      id_shamt_i,
  output logic            ex_valid_o,
  output logic            ex_regwrite_o,
  output logic            ex_memtoreg_o,
  output logic            ex_memwrite_o,
  output logic            ex_alusrc_o,
  output logic            ex_regdst_o,
  output logic            ex_jump_o,
  output logic            ex_branch_o,
  output logic [1:0]      ex_branch_condition_o,
  output logic [3:0]      ex_alucontrol_o,
  output logic [DW-1:0]   ex_rd1_o,
  output logic [DW-1:0]   ex_rd2_o,
  output logic [DW-1:0]   ex_imm_o,
  output logic [DW-1:0]   ex_pcplus4_o,
  output logic [4:0]      ex_rs_o,
  output logic [4:0]      ex_rt_o,
  output logic [4:0]      ex_rd_o,
  output logic [4:0]      ex_shamt_o,
  output logic            stall_o,
  output logic [CNTW-1:0] bubble_cnt_o
);

  logic bubble;

`ifdef ID_EX_HAZARD_DETECT_EN
  logic uses_rt;
  logic rs_hit;
  logic rt_hit;

  assign uses_rt = id_regdst_i | id_memwrite_i | id_branch_i;
  assign rs_hit  = (ex_rt_o == id_rs_i);
  assign rt_hit  = uses_rt & (ex_rt_o == id_rt_i);

  // Loads write rt; $0 is never a real destination.
  assign stall_o = ex_valid_o & ex_memtoreg_o
                 & (ex_rt_o != 5'd0)
                 & id_valid_i & ~flush_i
                 & (rs_hit | rt_hit);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bubble_cnt_o <= '0;
    end else if (stall_o && !(&bubble_cnt_o)) begin
      bubble_cnt_o <= bubble_cnt_o
                    + {{(CNTW-1){1'b0}}, 1'b1};
    end
  end
`else
  assign stall_o      = 1'b0;
  assign bubble_cnt_o = '0;
`endif

  assign bubble = flush_i | stall_o;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid_o            <= 1'b0;
      ex_regwrite_o         <= 1'b0;
      ex_memtoreg_o         <= 1'b0;
      ex_memwrite_o         <= 1'b0;
      ex_alusrc_o           <= 1'b0;
      ex_regdst_o           <= 1'b0;
      ex_jump_o             <= 1'b0;
      ex_branch_o           <= 1'b0;
      ex_branch_condition_o <= 2'd0;
      ex_alucontrol_o       <= 4'd0;
    end else if (bubble) begin
      ex_valid_o            <= 1'b0;
      ex_regwrite_o         <= 1'b0;
      ex_memtoreg_o         <= 1'b0;
      ex_memwrite_o         <= 1'b0;
      ex_alusrc_o           <= 1'b0;
      ex_regdst_o           <= 1'b0;
      ex_jump_o             <= 1'b0;
      ex_branch_o           <= 1'b0;
      ex_branch_condition_o <= 2'd0;
      ex_alucontrol_o       <= 4'd0;
    end else begin
      ex_valid_o            <= id_valid_i;
      ex_regwrite_o         <= id_regwrite_i;
      ex_memtoreg_o         <= id_memtoreg_i;
      ex_memwrite_o         <= id_memwrite_i;
      ex_alusrc_o           <= id_alusrc_i;
      ex_regdst_o           <= id_regdst_i;
      ex_jump_o             <= id_jump_i;
      ex_branch_o           <= id_branch_i;
      ex_branch_condition_o <= id_branch_condition_i;
      ex_alucontrol_o       <= id_alucontrol_i;
    end
  end

  // Data and fields load even on a bubble; downstream ignores them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_rd1_o     <= '0;
      ex_rd2_o     <= '0;
      ex_imm_o     <= '0;
      ex_pcplus4_o <= '0;
      ex_rs_o      <= 5'd0;
      ex_rt_o      <= 5'd0;
      ex_rd_o      <= 5'd0;
      ex_shamt_o   <= 5'd0;
    end else begin
      ex_rd1_o     <= id_rd1_i;
      ex_rd2_o     <= id_rd2_i;
      ex_imm_o     <= id_imm_i;
      ex_pcplus4_o <= id_pcplus4_i;
      ex_rs_o      <= id_rs_i;
      ex_rt_o      <= id_rt_i;
      ex_rd_o      <= id_rd_i;
      ex_shamt_o   <= id_shamt_i;
    end
  end

endmodule
